// File: rtl/avalon_pio_pkg.sv
// ----------------------------------------------------------------------------
// avalon_pio_pkg
//   Shared definitions for the edge-capturing Avalon-MM PIO block:
//     - register word addresses
//     - EDGE_TYPE encodings
//     - INFO register field positions
//     - edge_hit(): per-bit edge qualifier used by the top level
// ----------------------------------------------------------------------------
package avalon_pio_pkg;

  // Register map (Avalon word addresses)
  localparam logic [1:0] ADDR_DATA     = 2'd0;  // filtered input value, RO
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;  // interrupt enable per bit, RW
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;  // sticky edge flags, W1C
  localparam logic [1:0] ADDR_INFO     = 2'd3;  // build information, RO

  // EDGE_TYPE encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  // INFO register layout
  localparam int INFO_WIDTH_BITS  = 6;  // bits 5:0 hold WIDTH
  localparam int INFO_DEBOUNCE_IX = 8;  // bit 8 flags the debounce filter

  // True when the transition prev -> cur matches the selected edge type.
  function automatic logic edge_hit(input int edge_type, input logic cur, input logic prev);
    logic hit;
    case (edge_type)
      EDGE_RISING:  hit = cur & ~prev;
      EDGE_FALLING: hit = ~cur & prev;
      default:      hit = cur ^ prev;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pio_bit_filter.sv
// ----------------------------------------------------------------------------
// pio_bit_filter
//   One input bit's front end: a SYNC_STAGES-deep synchroniser followed, when
//   AVALON_EDGE_PIO_DEBOUNCE_EN is defined, by a stable-count debounce filter.
//   Without the macro the synchronised bit is passed straight through.
//
//   Build macro: AVALON_EDGE_PIO_DEBOUNCE_EN (enables the debounce counter)
//
//   Ports
//     clk       in   clock
//     reset_n   in   asynchronous active-low reset
//     in_bit    in   asynchronous raw input
//     filt_bit  out  filtered value (debounced or just synchronised)
// ----------------------------------------------------------------------------
module pio_bit_filter #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  output logic filt_bit
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_bit;

  // Shift chain: bit 0 samples the pin, the top bit is the safe copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], in_bit};
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];

`ifdef AVALON_EDGE_PIO_DEBOUNCE_EN

  // The counter holds how many consecutive clocks the synchronised bit has
  // disagreed with the filtered value; on the DEBOUNCE_CYCLES-th disagreeing
  // clock the filtered value follows and the count restarts.
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt_reg;
  logic [15:0] cnt_next;
  logic        filt_reg;
  logic        filt_next;

  always_comb begin
    cnt_next  = cnt_reg;
    filt_next = filt_reg;
    if (sync_bit == filt_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      filt_next = sync_bit;
      cnt_next  = '0;
    end else begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      filt_reg <= filt_next;
    end
  end

  assign filt_bit = filt_reg;

`else

  assign filt_bit = sync_bit;

  // DEBOUNCE_CYCLES only matters when the filter is built in.
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);

`endif

endmodule

// File: rtl/avalon_edge_pio.sv
// ----------------------------------------------------------------------------
// avalon_edge_pio
//   Avalon-MM slave PIO with per-bit edge capture and a level interrupt.
//   Each in_port bit is synchronised (and optionally debounced) by a
//   pio_bit_filter instance; edges on the filtered value set sticky flags in
//   EDGE_CAPTURE, which are write-1-to-clear and gated by IRQ_MASK into irq.
//
//   Build macro: AVALON_EDGE_PIO_DEBOUNCE_EN (debounce filter per bit)
//
//   Register map (word addresses)
//     0 DATA          RO   filtered input value
//     1 IRQ_MASK      RW   interrupt enable per bit
//     2 EDGE_CAPTURE  R/W1C sticky edge flags
//     3 INFO          RO   [5:0] WIDTH, [8] debounce built in
//
//   Ports
//     clk         in   clock
//     reset_n     in   asynchronous active-low reset
//     address     in   [1:0]  word address
//     chipselect  in   slave select
//     write_n     in   active-low write strobe
//     writedata   in   [31:0] write data
//     in_port     in   [WIDTH-1:0] asynchronous sensor inputs
//     readdata    out  [31:0] registered read data (1-cycle latency)
//     irq         out  level interrupt, active high
// ----------------------------------------------------------------------------
module avalon_edge_pio #(
  parameter int WIDTH           = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  import avalon_pio_pkg::*;

`ifdef AVALON_EDGE_PIO_DEBOUNCE_EN
  localparam logic DEBOUNCE_BUILT = 1'b1;
`else
  localparam logic DEBOUNCE_BUILT = 1'b0;
`endif

  // Edge detection stays off until the previous-sample register holds a
  // real sample: the synchroniser needs SYNC_STAGES clocks to fill and the
  // previous-sample register one more.
  localparam logic [2:0] WARM_CYCLES = 3'(SYNC_STAGES + 1);

  localparam logic [31:0] INFO_WORD = {
    {(31 - INFO_DEBOUNCE_IX){1'b0}},
    DEBOUNCE_BUILT,
    {(INFO_DEBOUNCE_IX - INFO_WIDTH_BITS){1'b0}},
    INFO_WIDTH_BITS'(WIDTH)
  };

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] edge_hits;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic [WIDTH-1:0] cap_reg;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] cap_clr;
  logic [2:0]       warm_reg;
  logic [2:0]       warm_next;
  logic             armed;
  logic             wr_en;
  logic [31:0]      readdata_reg;
  logic [31:0]      readdata_next;
  logic             irq_reg;
  logic             irq_next;

  // --------------------------------------------------------------------------
  // Per-bit front end and edge qualification
  // --------------------------------------------------------------------------
  assign armed = (warm_reg == WARM_CYCLES);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_bit_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_bit   (in_port[gi]),
        .filt_bit (filt[gi])
      );

      assign edge_hits[gi] = armed & edge_hit(EDGE_TYPE, filt[gi], prev_reg[gi]);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Register writes
  // --------------------------------------------------------------------------
  assign wr_en = chipselect & ~write_n;

  always_comb begin
    mask_next = mask_reg;
    cap_clr   = '0;
    if (wr_en && (address == ADDR_IRQ_MASK)) begin
      mask_next = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE_CAP)) begin
      cap_clr = writedata[WIDTH-1:0];
    end
    // OR-ing the new edges in after the clear makes a same-cycle edge win.
    cap_next  = (cap_reg & ~cap_clr) | edge_hits;
    warm_next = armed ? warm_reg : warm_reg + 3'd1;
    irq_next  = |(cap_reg & mask_reg);
  end

  // --------------------------------------------------------------------------
  // Read mux (registered every clock regardless of chipselect)
  // --------------------------------------------------------------------------
  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_DATA:     readdata_next = 32'(filt);
      ADDR_IRQ_MASK: readdata_next = 32'(mask_reg);
      ADDR_EDGE_CAP: readdata_next = 32'(cap_reg);
      default:       readdata_next = INFO_WORD;
    endcase
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_reg     <= '0;
      warm_reg     <= '0;
      mask_reg     <= '0;
      cap_reg      <= '0;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      prev_reg     <= filt;
      warm_reg     <= warm_next;
      mask_reg     <= mask_next;
      cap_reg      <= cap_next;
      readdata_reg <= readdata_next;
      irq_reg      <= irq_next;
    end
  end

  assign readdata = readdata_reg;
  assign irq      = irq_reg;

  // Upper writedata bits beyond WIDTH carry no meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

endmodule
